nark_mem_stage: RTL and testbench
=================================

// Module: nark_mem_stage
// PURPOSE
//  Parametrised MEM pipeline stage: data RAM of configurable depth and access latency,
//  word and byte load/store modes, and EX->M pipeline registers (read data, ALU result,
//  write address, valid).
//  Sits between the EX stage and WB, and stalls EX while a multi-cycle access runs.
//  Supports flush, which squashes an in-flight operation.
// PARAMETERS
//  BITS       24  datapath width; multiple of 8
//  ADDR_BITS  8   RAM index width; DEPTH = 2**ADDR_BITS words
//  LATENCY    1   cycles a memory op occupies the stage (1..8)
//  WA_BITS    4   register-file write-address width
// PORTS
//  CLK           in   1          clock, rising edge
//  RST           in   1          asynchronous, active-low reset
//  valid_e       in   1          EX presents an op
//  mem_read_e    in   1          op is a load
//  mem_write_e   in   1          op is a store (mem_read_e and mem_write_e both 1 -> store wins)
//  size_e        in   2          mem_size_t: WORD, BYTE_U, BYTE_S
//  alu_result_e  in   BITS       address / pass-through result
//  write_data_e  in   BITS       store data
//  wa_e          in   WA_BITS    destination register
//  flush         in   1          squash in-flight op and the op on the EX inputs
//  stall_m       out  1          EX must hold its inputs
//  valid_m       out  1          M outputs valid this cycle
//  read_data_m   out  BITS       extended load data; 0 for non-loads
//  alu_out_m     out  BITS       registered alu_result_e
//  wa_m          out  WA_BITS    registered wa_e
//  err_m         out  1          range error (MEM_RANGE_CHECK_EN only)
// BEHAVIOUR
//  - Reset: every output 0, FSM in IDLE, counter 0. RAM contents are not cleared.
//  - Accept: valid_e & ~stall_m & ~flush. Non-memory op -> M regs updated next edge, valid_m=1 one cycle.
//  - Memory op, LATENCY=1: same timing as a non-memory op; stall_m never asserted.
//  - Memory op, LATENCY=N>1: address, data, size and wa latched at accept; FSM IDLE->BUSY.
//    stall_m=1 (combinational from state) for N-1 cycles. On the last BUSY edge:
//    store commits, load data captured, M regs updated, valid_m=1, FSM->IDLE.
//  - Back-to-back ops: a new op can be accepted on the cycle after valid_m.
//  - FSM: IDLE->BUSY on accepted memory op with N>1. BUSY->IDLE when cnt==N-1 or on flush.
//  - Flush in BUSY: no RAM write, valid_m=0, return to IDLE. Flush in IDLE: inputs ignored.
//  - No accept: valid_m=0; data outputs hold last values.
//  - Index = alu_result[ADDR_BITS-1:0]; higher address bits are ignored unless range check is enabled.
//  - Store WORD writes the full word. Store BYTE_* writes bits[7:0] only (lane-0 byte enable); other bits kept.
//  - Load WORD returns the full word. BYTE_U zero-extends bits[7:0]; BYTE_S sign-extends bit 7 to BITS.
//  - Reset asserted mid-BUSY: op abandoned, nothing written, outputs 0.
// CONFIGURATION
//  MEM_RANGE_CHECK_EN defined: any alu_result bit above ADDR_BITS-1 set on a memory op means
//    the store is suppressed, read_data_m=0 and err_m=1 with that op's valid_m; timing unchanged.
//  MEM_RANGE_CHECK_EN undefined: address wraps modulo DEPTH; err_m tied 0.
// STRUCTURE
//  Package nark_mem_pkg: mem_size_t enum (WORD=0, BYTE_U=1, BYTE_S=2), mem_state_t {IDLE,BUSY},
//    and a function that extends a loaded word according to mem_size_t.
//  Sub-module nark_data_ram: synchronous single-port RAM; we, lane-0 byte enable, registered read.
// TESTING (BITS=24, ADDR_BITS=8, LATENCY=3 unless noted)
//  1 Store WORD 0xABCDEF @0x10, then load WORD @0x10 -> stall_m 2 cycles each op; read_data_m=0xABCDEF.
//  2 Store BYTE 0x80 @0x10, then load BYTE_S -> 0xFFFF80; load BYTE_U -> 0x000080; load WORD -> 0xABCD80.
//  3 Non-memory op, alu=0x123456, wa=5 -> next cycle valid_m=1, alu_out_m=0x123456, wa_m=5, no stall.
//  4 Store 0x111111 @0x20, flush on its 2nd BUSY cycle -> valid_m stays 0; later load @0x20 returns old contents.
//  5 LATENCY=1: alternating store/load @0x00-0x03 every cycle -> stall_m always 0; each load returns its data.
//  6 MEM_RANGE_CHECK_EN, store @0x100 -> err_m=1, RAM @0x00 unchanged; without the macro -> write lands @0x00.

Source files
------------

// File: rtl/nark_mem_pkg.sv
// nark_mem_pkg
//   Shared types for the MEM stage.
//   - mem_size_t  : access size (WORD, BYTE_U, BYTE_S)
//   - mem_state_t : stage FSM state (IDLE, BUSY)
//   - mem_extend  : extends a loaded word according to its access size
//   The extension function works on a MEM_MAX_W-wide word. Callers zero-extend
//   their data into it and truncate the result, so any datapath width up to
//   MEM_MAX_W is supported.
package nark_mem_pkg;

  typedef enum logic [1:0] {
    WORD   = 2'd0,
    BYTE_U = 2'd1,
    BYTE_S = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam int MEM_MAX_W = 64;
  localparam int MEM_CNT_W = 4;

  function automatic logic [MEM_MAX_W-1:0] mem_extend(input logic [MEM_MAX_W-1:0] w,
                                                      input mem_size_t              sz);
    case (sz)
      BYTE_U:  return {{(MEM_MAX_W-8){1'b0}}, w[7:0]};
      BYTE_S:  return {{(MEM_MAX_W-8){w[7]}}, w[7:0]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/nark_data_ram.sv
// nark_data_ram
//   Synchronous single-port data RAM with a registered read port.
//   Ports:
//     clk_i    : clock, rising edge
//     en_i     : access enable; the read register only updates when enabled
//     we_i     : write enable (qualified by en_i)
//     byte_i   : 1 -> only bits [7:0] are written (lane-0 byte enable)
//     addr_i   : word index
//     wdata_i  : write data
//     rdata_o  : read data, registered (old contents on a same-cycle write)
//   Contents are never cleared.
module nark_data_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        if (byte_i) mem_q[addr_i][7:0] <= wdata_i[7:0];
        else        mem_q[addr_i]      <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/nark_mem_stage.sv
// nark_mem_stage
//   MEM pipeline stage: data RAM access (word / byte loads and stores) plus the
//   EX->M pipeline registers. A memory op occupies the stage for LATENCY cycles;
//   with LATENCY>1 the op is latched, EX is stalled for LATENCY-1 cycles and the
//   access is committed on the last BUSY edge.
//   Ports:
//     CLK, RST        : clock (rising edge), asynchronous active-low reset
//     valid_e         : EX presents an op
//     mem_read_e      : op is a load
//     mem_write_e     : op is a store (wins over mem_read_e)
//     size_e          : WORD / BYTE_U / BYTE_S
//     alu_result_e    : address or pass-through result
//     write_data_e    : store data
//     wa_e            : destination register
//     flush           : squash the in-flight op and the op on the EX inputs
//     stall_m         : EX must hold its inputs
//     valid_m         : M outputs valid this cycle
//     read_data_m     : extended load data, 0 for non-loads
//     alu_out_m, wa_m : registered alu_result_e / wa_e
//     err_m           : address range error, pulses with the op's valid_m
//   Build option: define MEM_RANGE_CHECK_EN to flag memory ops whose address has
//   bits set above ADDR_BITS-1 (store suppressed, read data 0, err_m=1).
//   Without it the address wraps modulo DEPTH and err_m is tied 0.
module nark_mem_stage
  import nark_mem_pkg::*;
#(
  parameter int BITS      = 24,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 1,
  parameter int WA_BITS   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               valid_e,
  input  logic               mem_read_e,
  input  logic               mem_write_e,
  input  mem_size_t          size_e,
  input  logic [BITS-1:0]    alu_result_e,
  input  logic [BITS-1:0]    write_data_e,
  input  logic [WA_BITS-1:0] wa_e,
  input  logic               flush,
  output logic               stall_m,
  output logic               valid_m,
  output logic [BITS-1:0]    read_data_m,
  output logic [BITS-1:0]    alu_out_m,
  output logic [WA_BITS-1:0] wa_m,
  output logic               err_m
);

  localparam bit MULTI = (LATENCY > 1);
  localparam logic [MEM_CNT_W-1:0] CNT_LAST = MEM_CNT_W'(LATENCY - 1);

  mem_state_t           state_q;
  logic [MEM_CNT_W-1:0] cnt_q;

  // Op latched at accept while a multi-cycle access runs
  logic [BITS-1:0]    op_alu_q;
  logic [BITS-1:0]    op_wd_q;
  mem_size_t          op_size_q;
  logic [WA_BITS-1:0] op_wa_q;
  logic               op_rd_q;
  logic               op_wr_q;

  // M-stage registers
  logic               valid_q;
  logic [BITS-1:0]    alu_q;
  logic [WA_BITS-1:0] wa_q;
  logic               load_q;
  mem_size_t          size_m_q;
  logic               err_q;

  logic            accept, mem_op_e, last_busy, commit;
  logic [BITS-1:0] c_alu, c_wd;
  mem_size_t       c_size;
  logic [WA_BITS-1:0] c_wa;
  logic            c_rd, c_wr, c_err, ram_en;
  logic [BITS-1:0] ram_rdata;

  assign stall_m   = (state_q == BUSY);
  assign accept    = valid_e & ~stall_m & ~flush;
  assign mem_op_e  = mem_read_e | mem_write_e;
  assign last_busy = (state_q == BUSY) & (cnt_q == CNT_LAST) & ~flush;

  // A non-memory op, or any op with single-cycle latency, commits on its accept
  // edge straight from the EX inputs; a multi-cycle op commits from the latch.
  assign commit = (accept & (~mem_op_e | ~MULTI)) | last_busy;

  assign c_alu  = last_busy ? op_alu_q  : alu_result_e;
  assign c_wd   = last_busy ? op_wd_q   : write_data_e;
  assign c_size = last_busy ? op_size_q : size_e;
  assign c_wa   = last_busy ? op_wa_q   : wa_e;
  assign c_wr   = last_busy ? op_wr_q   : mem_write_e;
  assign c_rd   = last_busy ? op_rd_q   : (mem_read_e & ~mem_write_e);

`ifdef MEM_RANGE_CHECK_EN
  assign c_err = (c_wr | c_rd) & ((c_alu >> ADDR_BITS) != '0);
`else
  assign c_err = 1'b0;
`endif

  // RST gating keeps inputs seen during reset from touching the RAM.
  assign ram_en = commit & (c_wr | c_rd) & ~c_err & RST;

  nark_data_ram #(
    .DATA_W (BITS),
    .ADDR_W (ADDR_BITS)
  ) u_ram (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (c_wr),
    .byte_i  (c_size != WORD),
    .addr_i  (c_alu[ADDR_BITS-1:0]),
    .wdata_i (c_wd),
    .rdata_o (ram_rdata)
  );

  // Stage FSM and op latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_alu_q  <= '0;
      op_wd_q   <= '0;
      op_size_q <= WORD;
      op_wa_q   <= '0;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept & mem_op_e & MULTI) begin
            state_q   <= BUSY;
            cnt_q     <= MEM_CNT_W'(1);
            op_alu_q  <= alu_result_e;
            op_wd_q   <= write_data_e;
            op_size_q <= size_e;
            op_wa_q   <= wa_e;
            op_wr_q   <= mem_write_e;
            op_rd_q   <= mem_read_e & ~mem_write_e;
          end
        end
        BUSY: begin
          if (flush || cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + MEM_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // M-stage registers: data fields hold between commits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q  <= 1'b0;
      alu_q    <= '0;
      wa_q     <= '0;
      load_q   <= 1'b0;
      size_m_q <= WORD;
      err_q    <= 1'b0;
    end else begin
      valid_q <= commit;
      err_q   <= commit & c_err;
      if (commit) begin
        alu_q    <= c_alu;
        wa_q     <= c_wa;
        load_q   <= c_rd & ~c_err;
        size_m_q <= c_size;
      end
    end
  end

  assign valid_m     = valid_q;
  assign alu_out_m   = alu_q;
  assign wa_m        = wa_q;
  assign err_m       = err_q;
  assign read_data_m = load_q ? BITS'(mem_extend(MEM_MAX_W'(ram_rdata), size_m_q)) : '0;

endmodule

// File: tb/tb_nark_mem_stage.sv
module tb_nark_mem_stage;
  import nark_mem_pkg::*;

  typedef struct packed {
    logic [23:0] rd;
    logic [23:0] alu;
    logic [3:0]  wa;
    logic        err;
  } exp_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  // LATENCY=3 instance
  logic v3, rd3, wr3, fl3;
  mem_size_t sz3;
  logic [23:0] alu3, wd3;
  logic [3:0]  wa3;
  logic stall3, vm3, err3;
  logic [23:0] rdm3, alum3;
  logic [3:0]  wam3;

  // LATENCY=1 instance
  logic v1, rd1, wr1, fl1;
  mem_size_t sz1;
  logic [23:0] alu1, wd1;
  logic [3:0]  wa1;
  logic stall1, vm1, err1;
  logic [23:0] rdm1, alum1;
  logic [3:0]  wam1;

  nark_mem_stage #(.BITS(24), .ADDR_BITS(8), .LATENCY(3), .WA_BITS(4)) dut3 (
    .CLK(CLK), .RST(RST), .valid_e(v3), .mem_read_e(rd3), .mem_write_e(wr3),
    .size_e(sz3), .alu_result_e(alu3), .write_data_e(wd3), .wa_e(wa3), .flush(fl3),
    .stall_m(stall3), .valid_m(vm3), .read_data_m(rdm3), .alu_out_m(alum3),
    .wa_m(wam3), .err_m(err3));

  nark_mem_stage #(.BITS(24), .ADDR_BITS(8), .LATENCY(1), .WA_BITS(4)) dut1 (
    .CLK(CLK), .RST(RST), .valid_e(v1), .mem_read_e(rd1), .mem_write_e(wr1),
    .size_e(sz1), .alu_result_e(alu1), .write_data_e(wd1), .wa_e(wa1), .flush(fl1),
    .stall_m(stall1), .valid_m(vm1), .read_data_m(rdm1), .alu_out_m(alum1),
    .wa_m(wam1), .err_m(err1));

  exp_t q3[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] rd, input logic [23:0] alu,
                              input logic [3:0] wa, input logic err);
    exp_t e;
    e.rd = rd; e.alu = alu; e.wa = wa; e.err = err;
    return e;
  endfunction

  // Monitors: pop one expectation per valid_m
  always @(negedge CLK) begin : mon3
    exp_t e;
    if (RST === 1'b1 && vm3 === 1'b1) begin
      if (q3.size() == 0) begin
        tests++; fails++;
        $display("FAIL m3 unexpected valid_m: alu_out 0x%0h wa %0d, no op expected", alum3, wam3);
      end else begin
        e = q3.pop_front();
        chk("m3 read_data_m", 64'(rdm3), 64'(e.rd));
        chk("m3 alu_out_m",   64'(alum3), 64'(e.alu));
        chk("m3 wa_m",        64'(wam3), 64'(e.wa));
        chk("m3 err_m",       64'(err3), 64'(e.err));
      end
    end
  end

  always @(negedge CLK) begin : mon1
    exp_t e;
    if (RST === 1'b1 && vm1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL m1 unexpected valid_m: alu_out 0x%0h wa %0d, no op expected", alum1, wam1);
      end else begin
        e = q1.pop_front();
        chk("m1 read_data_m", 64'(rdm1), 64'(e.rd));
        chk("m1 alu_out_m",   64'(alum1), 64'(e.alu));
        chk("m1 wa_m",        64'(wam1), 64'(e.wa));
        chk("m1 err_m",       64'(err1), 64'(e.err));
      end
    end
  end

  // Issue one op to the LATENCY=3 instance and count its stall cycles
  task automatic op3(input logic r, input logic w, input mem_size_t s,
                     input logic [23:0] a, input logic [23:0] d, input logic [3:0] wa,
                     input int exp_stall, input exp_t e, input string name);
    int n;
    @(negedge CLK);
    v3 = 1'b1; rd3 = r; wr3 = w; sz3 = s; alu3 = a; wd3 = d; wa3 = wa;
    q3.push_back(e);
    @(posedge CLK); #1;
    v3 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    n = 0;
    while (stall3 === 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({name, " stall cycles"}, 64'(n), 64'(exp_stall));
  endtask

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    logic [23:0] dtab [4];
    logic [23:0] rexp;
    dtab[0] = 24'h13579B; dtab[1] = 24'h2468AC; dtab[2] = 24'hFEDCBA; dtab[3] = 24'h00FF00;

    RST = 1'b0;
    v3 = 0; rd3 = 0; wr3 = 0; fl3 = 0; sz3 = WORD; alu3 = 0; wd3 = 0; wa3 = 0;
    v1 = 0; rd1 = 0; wr1 = 0; fl1 = 0; sz1 = WORD; alu1 = 0; wd1 = 0; wa1 = 0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("reset valid_m3",  64'(vm3), 0);
    chk("reset stall_m3",  64'(stall3), 0);
    chk("reset rdata3",    64'(rdm3), 0);
    chk("reset alu_out3",  64'(alum3), 0);
    chk("reset wa_m3",     64'(wam3), 0);
    chk("reset err_m3",    64'(err3), 0);
    chk("reset valid_m1",  64'(vm1), 0);
    chk("reset stall_m1",  64'(stall1), 0);
    @(negedge CLK);
    RST = 1'b1;

    // Word store / load
    op3(0, 1, WORD, 24'h000010, 24'hABCDEF, 4'd1, 2, mk(24'h0, 24'h10, 4'd1, 0), "t1 store");
    op3(1, 0, WORD, 24'h000010, 24'h0,      4'd2, 2, mk(24'hABCDEF, 24'h10, 4'd2, 0), "t1 load");

    // Byte store, then byte / word loads
    op3(0, 1, BYTE_U, 24'h000010, 24'h555580, 4'd3, 2, mk(24'h0, 24'h10, 4'd3, 0), "t2 store byte");
    op3(1, 0, BYTE_S, 24'h000010, 24'h0, 4'd4, 2, mk(24'hFFFF80, 24'h10, 4'd4, 0), "t2 load byte_s");
    op3(1, 0, BYTE_U, 24'h000010, 24'h0, 4'd5, 2, mk(24'h000080, 24'h10, 4'd5, 0), "t2 load byte_u");
    op3(1, 0, WORD,   24'h000010, 24'h0, 4'd6, 2, mk(24'hABCD80, 24'h10, 4'd6, 0), "t2 load word");

    // Non-memory op
    op3(0, 0, WORD, 24'h123456, 24'h777777, 4'd5, 0, mk(24'h0, 24'h123456, 4'd5, 0), "t3 alu op");

    // Read and write both set: store wins, read data 0
    op3(1, 1, WORD, 24'h000030, 24'h0000AA, 4'd7, 2, mk(24'h0, 24'h30, 4'd7, 0), "rw store");
    op3(1, 0, WORD, 24'h000030, 24'h0,      4'd8, 2, mk(24'h0000AA, 24'h30, 4'd8, 0), "rw load");

    // Flush during BUSY squashes the store
    op3(0, 1, WORD, 24'h000020, 24'h222222, 4'd1, 2, mk(24'h0, 24'h20, 4'd1, 0), "t4 store old");
    @(negedge CLK);
    v3 = 1'b1; wr3 = 1'b1; sz3 = WORD; alu3 = 24'h20; wd3 = 24'h111111; wa3 = 4'd2;
    @(posedge CLK); #1;
    v3 = 1'b0; wr3 = 1'b0;
    chk("t4 stall after accept", 64'(stall3), 1);
    @(posedge CLK); #1;
    fl3 = 1'b1;
    @(posedge CLK); #1;
    fl3 = 1'b0;
    chk("t4 stall after flush", 64'(stall3), 0);
    chk("t4 valid after flush", 64'(vm3), 0);
    // Flush in IDLE: op on the inputs is ignored
    @(negedge CLK);
    v3 = 1'b1; wr3 = 1'b1; alu3 = 24'h20; wd3 = 24'h333333; wa3 = 4'd3; fl3 = 1'b1;
    @(posedge CLK); #1;
    v3 = 1'b0; wr3 = 1'b0; fl3 = 1'b0;
    chk("t4 idle flush stall", 64'(stall3), 0);
    repeat (3) @(posedge CLK);
    op3(1, 0, WORD, 24'h000020, 24'h0, 4'd4, 2, mk(24'h222222, 24'h20, 4'd4, 0), "t4 load old");

    // Reset asserted mid-BUSY abandons the store
    op3(0, 1, WORD, 24'h000040, 24'h444444, 4'd1, 2, mk(24'h0, 24'h40, 4'd1, 0), "rst store old");
    @(negedge CLK);
    v3 = 1'b1; wr3 = 1'b1; alu3 = 24'h40; wd3 = 24'h999999; wa3 = 4'd9;
    @(posedge CLK); #1;
    v3 = 1'b0; wr3 = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("rst busy stall_m",  64'(stall3), 0);
    chk("rst busy valid_m",  64'(vm3), 0);
    chk("rst busy alu_out",  64'(alum3), 0);
    chk("rst busy wa_m",     64'(wam3), 0);
    chk("rst busy rdata",    64'(rdm3), 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    op3(1, 0, WORD, 24'h000040, 24'h0, 4'd2, 2, mk(24'h444444, 24'h40, 4'd2, 0), "rst load old");

    // Out-of-range address
    op3(0, 1, WORD, 24'h000000, 24'h000777, 4'd1, 2, mk(24'h0, 24'h0, 4'd1, 0), "t6 preload");
`ifdef MEM_RANGE_CHECK_EN
    op3(0, 1, WORD, 24'h000100, 24'h0BEEF1, 4'd9, 2, mk(24'h0, 24'h100, 4'd9, 1), "t6 store oor");
    op3(1, 0, WORD, 24'h000100, 24'h0, 4'd11, 2, mk(24'h0, 24'h100, 4'd11, 1), "t6 load oor");
    rexp = 24'h000777;
`else
    op3(0, 1, WORD, 24'h000100, 24'h0BEEF1, 4'd9, 2, mk(24'h0, 24'h100, 4'd9, 0), "t6 store wrap");
    rexp = 24'h0BEEF1;
`endif
    op3(1, 0, WORD, 24'h000000, 24'h0, 4'd10, 2, mk(rexp, 24'h0, 4'd10, 0), "t6 load @0");

    // LATENCY=1: alternating store/load every cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk("t5 stall_m1", 64'(stall1), 0);
      v1 = 1'b1; sz1 = WORD; alu1 = 24'(i / 2); wa1 = 4'(i);
      if (i % 2 == 0) begin
        wr1 = 1'b1; rd1 = 1'b0; wd1 = dtab[i/2];
        q1.push_back(mk(24'h0, 24'(i / 2), 4'(i), 0));
      end else begin
        wr1 = 1'b0; rd1 = 1'b1; wd1 = 24'h0;
        q1.push_back(mk(dtab[i/2], 24'(i / 2), 4'(i), 0));
      end
    end
    @(negedge CLK);
    chk("t5 stall_m1 end", 64'(stall1), 0);
    v1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0;

    repeat (4) @(negedge CLK);
    #1;
    chk("q3 drained", 64'(q3.size()), 0);
    chk("q1 drained", 64'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
